// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/acknowledge port of the fetch stage.
interface fetch_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Fetch side drives the request, memory side answers it.
    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC and keeps one instruction memory
// request outstanding at a time. Returned words go into a one-entry buffer
// for decode. Decode stalls hold the buffer, and branch redirects squash
// wrong-path returns.
module fetch_sequencer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall_d,
    input  logic                      pcsrc_d,
    input  logic [31:0]               pc_branch_d,
    fetch_sequencer_if.master         mem,
    output logic [31:0]               instr_f,
    output logic [31:0]               pc_plus_4f,
    output logic                      instr_valid_f,
    output logic                      stall_miss,
    output logic                      err
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_plus_4_q, pc_plus_4_d;
    logic              instr_valid_q, instr_valid_d;
    logic              discard_q, discard_d;
    logic [31:0]       hold_addr_q, hold_addr_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic        in_fetch;
    logic        ack;
    logic        consume;
    logic        redirect;
    logic        timeout;
    logic [31:0] pc_inc;

    assign in_fetch = (state_q == S_FETCH);
    assign ack      = in_fetch & mem.mem_ack;
    assign consume  = instr_valid_q & ~stall_d;
    assign redirect = pcsrc_d & ~stall_d;
    assign timeout  = in_fetch & ~mem.mem_ack & (wait_cnt_q == WAIT_LAST);
    assign pc_inc   = pc_q + 32'd4;

    // Next-state, PC, buffer and handshake bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_plus_4_d   = pc_plus_4_q;
        instr_valid_d = instr_valid_q;
        discard_d     = discard_q;
        hold_addr_d   = hold_addr_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;

        if (consume) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ack) begin
                    wait_cnt_d = '0;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (stall_d && instr_valid_q) begin
                        // Buffer still occupied: drop the word, refetch the same pc later.
                        state_d = S_HOLD;
                    end else begin
                        instr_d       = mem.mem_rdata;
                        pc_plus_4_d   = pc_inc;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_inc;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_HOLD: begin
                if (!stall_d) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
                err_d         = 1'b1;
            end
        endcase

        // A redirect overrides everything except a memory timeout or the error state.
        if (redirect && (state_q != S_ERROR) && !timeout) begin
            pc_d          = pc_branch_d;
            instr_d       = instr_q;
            pc_plus_4_d   = pc_plus_4_q;
            instr_valid_d = 1'b0;
            state_d       = S_FETCH;
            if (in_fetch && !mem.mem_ack) begin
                // The request in flight is wrong-path: keep its address and squash its return.
                discard_d = 1'b1;
                if (!discard_q) begin
                    hold_addr_d = pc_q;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_BOOT;
            pc_q          <= BOOT_ADDR;
            instr_q       <= '0;
            pc_plus_4_q   <= '0;
            instr_valid_q <= 1'b0;
            discard_q     <= 1'b0;
            hold_addr_q   <= '0;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_plus_4_q   <= pc_plus_4_d;
            instr_valid_q <= instr_valid_d;
            discard_q     <= discard_d;
            hold_addr_q   <= hold_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
        end
    end

    assign mem.mem_req   = in_fetch;
    assign mem.mem_addr  = discard_q ? hold_addr_q : pc_q;
    assign stall_miss    = in_fetch & ~mem.mem_ack;
    assign instr_f       = instr_q;
    assign pc_plus_4f    = pc_plus_4_q;
    assign instr_valid_f = instr_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_d;
    logic        pcsrc_d;
    logic [31:0] pc_branch_d;
    logic [31:0] instr_f;
    logic [31:0] pc_plus_4f;
    logic        instr_valid_f;
    logic        stall_miss;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer_if mif ();

    fetch_sequencer #(
        .BOOT_ADDR (32'h0000_0100),
        .MAX_WAIT  (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_d       (stall_d),
        .pcsrc_d       (pcsrc_d),
        .pc_branch_d   (pc_branch_d),
        .mem           (mif),
        .instr_f       (instr_f),
        .pc_plus_4f    (pc_plus_4f),
        .instr_valid_f (instr_valid_f),
        .stall_miss    (stall_miss),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        stall_d       = 1'b0;
        pcsrc_d       = 1'b0;
        pc_branch_d   = '0;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = '0;

        // Reset with ack tied high
        tick();
        tick();
        #2;
        chk("rst_valid", 32'(instr_valid_f), 32'd0);
        chk("rst_instr", instr_f, 32'h0);
        chk("rst_pp4", pc_plus_4f, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        chk("rst_miss", 32'(stall_miss), 32'd0);
        reset_n = 1'b1;
        tick();

        // Streaming at one word per cycle
        mif.mem_rdata = 32'hCAFE_0100;
        #2;
        chk("a_addr", mif.mem_addr, 32'h100);
        chk("a_req", 32'(mif.mem_req), 32'd1);
        chk("a_miss", 32'(stall_miss), 32'd0);
        chk("a_valid", 32'(instr_valid_f), 32'd0);
        tick();
        mif.mem_rdata = 32'hCAFE_0104;
        #2;
        chk("b_valid", 32'(instr_valid_f), 32'd1);
        chk("b_instr", instr_f, 32'hCAFE_0100);
        chk("b_pp4", pc_plus_4f, 32'h104);
        chk("b_addr", mif.mem_addr, 32'h104);
        tick();
        mif.mem_rdata = 32'hCAFE_0108;
        #2;
        chk("c_addr", mif.mem_addr, 32'h108);
        chk("c_instr", instr_f, 32'hCAFE_0104);
        chk("c_pp4", pc_plus_4f, 32'h108);
        tick();

        // Ack delayed 3 cycles
        mif.mem_ack = 1'b0;
        #2;
        chk("d_addr", mif.mem_addr, 32'h10C);
        chk("d_miss", 32'(stall_miss), 32'd1);
        chk("d_instr", instr_f, 32'hCAFE_0108);
        chk("d_valid", 32'(instr_valid_f), 32'd1);
        tick();
        #2;
        chk("e_addr", mif.mem_addr, 32'h10C);
        chk("e_miss", 32'(stall_miss), 32'd1);
        chk("e_valid", 32'(instr_valid_f), 32'd0);
        tick();
        #2;
        chk("f_addr", mif.mem_addr, 32'h10C);
        chk("f_miss", 32'(stall_miss), 32'd1);
        tick();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hCAFE_010C;
        #2;
        chk("g_miss", 32'(stall_miss), 32'd0);
        chk("g_addr", mif.mem_addr, 32'h10C);
        chk("g_valid", 32'(instr_valid_f), 32'd0);
        tick();

        // Decode stall for 4 cycles with a full buffer
        stall_d       = 1'b1;
        mif.mem_rdata = 32'hCAFE_0110;
        #2;
        chk("h_valid", 32'(instr_valid_f), 32'd1);
        chk("h_instr", instr_f, 32'hCAFE_010C);
        chk("h_pp4", pc_plus_4f, 32'h110);
        chk("h_addr", mif.mem_addr, 32'h110);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_req", 32'(mif.mem_req), 32'd0);
            chk("hold_instr", instr_f, 32'hCAFE_010C);
            chk("hold_pp4", pc_plus_4f, 32'h110);
            chk("hold_valid", 32'(instr_valid_f), 32'd1);
            tick();
        end
        stall_d = 1'b0;
        #2;
        chk("l_req", 32'(mif.mem_req), 32'd0);
        chk("l_valid", 32'(instr_valid_f), 32'd1);
        tick();
        #2;
        chk("m_req", 32'(mif.mem_req), 32'd1);
        chk("m_addr", mif.mem_addr, 32'h110);
        chk("m_valid", 32'(instr_valid_f), 32'd0);
        tick();

        // Redirect while a request is pending
        mif.mem_ack = 1'b0;
        pcsrc_d     = 1'b1;
        pc_branch_d = 32'h200;
        #2;
        chk("n_valid", 32'(instr_valid_f), 32'd1);
        chk("n_instr", instr_f, 32'hCAFE_0110);
        chk("n_pp4", pc_plus_4f, 32'h114);
        chk("n_addr", mif.mem_addr, 32'h114);
        tick();
        pcsrc_d = 1'b0;
        #2;
        chk("o_addr", mif.mem_addr, 32'h114);
        chk("o_miss", 32'(stall_miss), 32'd1);
        chk("o_valid", 32'(instr_valid_f), 32'd0);
        tick();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hDEAD_0114;
        #2;
        chk("p_addr", mif.mem_addr, 32'h114);
        chk("p_valid", 32'(instr_valid_f), 32'd0);
        tick();
        mif.mem_ack = 1'b0;
        #2;
        chk("q_addr", mif.mem_addr, 32'h200);
        chk("q_valid", 32'(instr_valid_f), 32'd0);
        chk("q_miss", 32'(stall_miss), 32'd1);
        tick();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hCAFE_0200;
        #2;
        chk("r_addr", mif.mem_addr, 32'h200);
        chk("r_valid", 32'(instr_valid_f), 32'd0);
        tick();

        // Redirect in the same cycle as an ack
        pcsrc_d       = 1'b1;
        pc_branch_d   = 32'h300;
        mif.mem_rdata = 32'hBAD0_0204;
        #2;
        chk("s_valid", 32'(instr_valid_f), 32'd1);
        chk("s_instr", instr_f, 32'hCAFE_0200);
        chk("s_pp4", pc_plus_4f, 32'h204);
        chk("s_addr", mif.mem_addr, 32'h204);
        tick();

        // Redirect under stall is ignored
        stall_d     = 1'b1;
        pc_branch_d = 32'h400;
        mif.mem_ack = 1'b0;
        #2;
        chk("t_addr", mif.mem_addr, 32'h300);
        chk("t_valid", 32'(instr_valid_f), 32'd0);
        chk("t_instr", instr_f, 32'hCAFE_0200);
        tick();
        pcsrc_d       = 1'b0;
        stall_d       = 1'b0;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hCAFE_0300;
        #2;
        chk("u_addr", mif.mem_addr, 32'h300);
        tick();

        // Timeout: ack held low
        mif.mem_ack = 1'b0;
        #2;
        chk("v_instr", instr_f, 32'hCAFE_0300);
        chk("v_pp4", pc_plus_4f, 32'h304);
        chk("v_valid", 32'(instr_valid_f), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("to_req", 32'(mif.mem_req), 32'd1);
            chk("to_err", 32'(err), 32'd0);
            chk("to_addr", mif.mem_addr, 32'h304);
            tick();
            #2;
        end
        chk("err_set", 32'(err), 32'd1);
        chk("err_req", 32'(mif.mem_req), 32'd0);
        chk("err_valid", 32'(instr_valid_f), 32'd0);
        chk("err_miss", 32'(stall_miss), 32'd0);
        mif.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("err_hold", 32'(err), 32'd1);
            chk("err_hold_req", 32'(mif.mem_req), 32'd0);
        end

        // Reset recovers and restarts at BOOT_ADDR
        reset_n = 1'b0;
        tick();
        #2;
        chk("rr_err", 32'(err), 32'd0);
        chk("rr_req", 32'(mif.mem_req), 32'd0);
        chk("rr_valid", 32'(instr_valid_f), 32'd0);
        reset_n = 1'b1;
        tick();
        #2;
        chk("rr_fetch_req", 32'(mif.mem_req), 32'd1);
        chk("rr_fetch_addr", mif.mem_addr, 32'h100);

        // PC wrap at the top of the address space
        pcsrc_d       = 1'b1;
        pc_branch_d   = 32'hFFFF_FFFC;
        mif.mem_rdata = 32'h0000_0001;
        tick();
        pcsrc_d       = 1'b0;
        mif.mem_rdata = 32'hCAFE_FFFC;
        #2;
        chk("w_addr", mif.mem_addr, 32'hFFFF_FFFC);
        chk("w_valid", 32'(instr_valid_f), 32'd0);
        tick();
        #2;
        chk("w2_valid", 32'(instr_valid_f), 32'd1);
        chk("w2_instr", instr_f, 32'hCAFE_FFFC);
        chk("w2_pp4", pc_plus_4f, 32'h0);
        chk("w2_addr", mif.mem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
